// File: rtl/lenet_frame_sequencer.sv
// lenet_frame_sequencer
// Frame-level controller for the parallel conv channel array. It pulses the
// shared channel start, streams one IMG_W x IMG_H frame from the image buffer
// onto the broadcast pixel bus, collects per-channel done flags, and flags a
// watchdog timeout if the channels never all report done.
module lenet_frame_sequencer #(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int NUM_CH  = 6,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     hold,
    output logic                     img_rd_en,
    output logic [ADDR_W-1:0]        img_rd_addr,
    input  logic signed [7:0]        img_rd_data,
    output logic                     ch_start,
    output logic                     ch_valid,
    output logic signed [7:0]        ch_pixel,
    input  logic [NUM_CH-1:0]        ch_layer_done,
    output logic [NUM_CH-1:0]        done_mask,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     timeout_err
);

    localparam int                NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam int                TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_DRAIN,
        S_WAIT_DONE,
        S_DONE,
        S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                drain_q, drain_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                err_q, err_d;

    logic                rd_en_c;
    logic                ch_start_c;
    logic                frame_done_c;
    logic [NUM_CH-1:0]   mask_seen;

    // Output pipeline: one stage matching the buffer read latency, one stage
    // capturing the returned pixel onto the broadcast bus.
    logic                rd_dly_q;
    logic                valid_q;
    logic signed [7:0]   pixel_q;

    // Includes flags arriving this cycle so completion is not delayed a cycle.
    assign mask_seen = mask_q | ch_layer_done;

    // Next-state and control decode for the frame sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drain_d      = 1'b0;
        to_d         = '0;
        mask_d       = mask_q;
        err_d        = err_q;
        rd_en_c      = 1'b0;
        ch_start_c   = 1'b0;
        frame_done_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_START;
                    mask_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_START: begin
                // Done flags during the start cycle are deliberately ignored.
                ch_start_c = 1'b1;
                cnt_d      = '0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                mask_d = mask_seen;
                if (!hold) begin
                    rd_en_c = 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Two cycles let the final read reach the pixel bus.
                mask_d  = mask_seen;
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                mask_d = mask_seen;
                to_d   = to_q + TO_W'(1);
                if (&mask_seen) begin
                    state_d = S_DONE;
                end else if (to_q == TO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                frame_done_c = 1'b1;
                state_d      = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, pixel counter, watchdog counter and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            to_q    <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            to_q    <= to_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    // Delay the read strobe to line up with buffer data, then register the pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_dly_q <= 1'b0;
            valid_q  <= 1'b0;
            pixel_q  <= '0;
        end else begin
            rd_dly_q <= rd_en_c;
            valid_q  <= rd_dly_q;
            if (rd_dly_q) begin
                pixel_q <= img_rd_data;
            end
        end
    end

    assign img_rd_en   = rd_en_c;
    assign img_rd_addr = cnt_q;
    assign ch_start    = ch_start_c;
    assign ch_valid    = valid_q;
    assign ch_pixel    = pixel_q;
    assign done_mask   = mask_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = frame_done_c;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_lenet_frame_sequencer.sv
// Self-checking bench for lenet_frame_sequencer: randomized frames checked
// against a cycle-level reference model of the frame protocol.
module tb_lenet_frame_sequencer;

    localparam int IMG_W   = 32;
    localparam int IMG_H   = 32;
    localparam int NUM_CH  = 6;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;
    localparam int NPIX    = IMG_W * IMG_H;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                frame_start = 1'b0;
    logic                hold = 1'b0;
    logic                img_rd_en;
    logic [ADDR_W-1:0]   img_rd_addr;
    logic signed [7:0]   img_rd_data = '0;
    logic                ch_start;
    logic                ch_valid;
    logic signed [7:0]   ch_pixel;
    logic [NUM_CH-1:0]   ch_layer_done = '0;
    logic [NUM_CH-1:0]   done_mask;
    logic                busy;
    logic                frame_done;
    logic                timeout_err;

    lenet_frame_sequencer #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .hold          (hold),
        .img_rd_en     (img_rd_en),
        .img_rd_addr   (img_rd_addr),
        .img_rd_data   (img_rd_data),
        .ch_start      (ch_start),
        .ch_valid      (ch_valid),
        .ch_pixel      (ch_pixel),
        .ch_layer_done (ch_layer_done),
        .done_mask     (done_mask),
        .busy          (busy),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Image buffer with one cycle read latency.
    logic [7:0] mem [NPIX];
    always @(posedge clk) begin
        if (img_rd_en) img_rd_data <= mem[img_rd_addr];
    end

    int n_vec  = 0;
    int n_miss = 0;
    int dw [NUM_CH];   // WAIT_DONE cycle index at which each channel pulses done (-1 none)
    int ds [NUM_CH];   // absolute frame cycle of an extra early pulse (-1 none)
    bit last_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            frame_start   = 1'b0;
            ch_layer_done = '0;
        end
    endtask

    // One frame: cyc 0 drives frame_start while the DUT is in IDLE.
    task automatic run_frame(input string name, input int hold_mode, input bit restart_mid);
        int lb, w, exp_end, fd_cyc, err_cyc, idle_cyc, beat, exp_addr;
        int start_cnt, fd_cnt, hold_viol, addr_err, lat_err, mask_err;
        bit rd_h1, rd_h2, ended, exp_err;
        logic [NUM_CH-1:0] exp_mask, mask_prev, pulse;
        lb = -1; exp_end = -1; fd_cyc = -1; err_cyc = -1; idle_cyc = -1;
        beat = 0; exp_addr = 0; start_cnt = 0; fd_cnt = 0;
        hold_viol = 0; addr_err = 0; lat_err = 0; mask_err = 0;
        rd_h1 = 1'b0; rd_h2 = 1'b0; ended = 1'b0; exp_err = 1'b0;
        exp_mask = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            frame_start = (cyc == 0) || (restart_mid && cyc == 200);
            case (hold_mode)
                1:       hold = ((cyc % 2) == 1);
                2:       hold = (($urandom % 3) == 0);
                default: hold = 1'b0;
            endcase
            pulse = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (ds[ch] == cyc) pulse[ch] = 1'b1;
                if (lb >= 0 && dw[ch] >= 0 && dw[ch] == cyc - lb - 1) pulse[ch] = 1'b1;
            end
            ch_layer_done = pulse;
            // Reference: mask collects flags from STREAM until the frame ends.
            mask_prev = exp_mask;
            if (cyc >= 2 && !ended) exp_mask = exp_mask | pulse;
            if (lb >= 0 && !ended) begin
                w = cyc - lb - 1;
                if (w >= 0) begin
                    if (&exp_mask) begin
                        ended = 1'b1; exp_end = cyc + 1; exp_err = 1'b0;
                    end else if (w == TIMEOUT - 1) begin
                        ended = 1'b1; exp_end = cyc + 1; exp_err = 1'b1;
                    end
                end
            end
            @(negedge clk);
            if (cyc == 0) check_eq({name, " err_before_start"}, timeout_err, last_err);
            if (cyc == 1) begin
                check_eq({name, " ch_start_cycle1"}, ch_start, 1);
                check_eq({name, " err_cleared"}, timeout_err, 0);
            end
            if (ch_start) start_cnt++;
            if (img_rd_en) begin
                if (hold) hold_viol++;
                if (img_rd_addr != ADDR_W'(exp_addr)) addr_err++;
                exp_addr++;
            end
            if (ch_valid !== rd_h2) lat_err++;
            rd_h2 = rd_h1;
            rd_h1 = img_rd_en;
            if (ch_valid) begin
                if (beat < NPIX)
                    check_eq($sformatf("%s pixel%0d", name, beat), {24'b0, ch_pixel}, {24'b0, mem[beat]});
                beat++;
                if (beat == NPIX) lb = cyc;
            end
            if (cyc >= 1 && done_mask !== mask_prev) mask_err++;
            if (frame_done) begin
                fd_cnt++;
                if (fd_cyc < 0) fd_cyc = cyc;
            end
            if (cyc >= 1 && timeout_err && err_cyc < 0) err_cyc = cyc;
            if (cyc >= 1 && !busy && idle_cyc < 0) idle_cyc = cyc;
            if (exp_end >= 0 && cyc >= exp_end + 2) break;
        end
        hold = 1'b0;
        ch_layer_done = '0;
        check_eq({name, " end_reached"}, (exp_end >= 0), 1);
        check_eq({name, " beats"}, beat, NPIX);
        check_eq({name, " start_pulses"}, start_cnt, 1);
        check_eq({name, " reads_in_hold"}, hold_viol, 0);
        check_eq({name, " addr_order"}, addr_err, 0);
        check_eq({name, " valid_latency"}, lat_err, 0);
        check_eq({name, " mask_track"}, mask_err, 0);
        check_eq({name, " done_mask"}, done_mask, exp_mask);
        check_eq({name, " busy_drop"}, idle_cyc, exp_end + 1);
        if (exp_err) begin
            check_eq({name, " no_frame_done"}, fd_cnt, 0);
            check_eq({name, " err_cycle"}, err_cyc, exp_end);
        end else begin
            check_eq({name, " frame_done_pulses"}, fd_cnt, 1);
            check_eq({name, " frame_done_cycle"}, fd_cyc, exp_end);
            check_eq({name, " no_err"}, err_cyc, -1);
        end
        last_err = exp_err;
        $display("frame %s: beats=%0d end_cycle=%0d err=%0d mask=%0h", name, beat, exp_end, exp_err, exp_mask);
    endtask

    task automatic set_done(input int lo, input int hi);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            dw[ch] = lo + int'($urandom_range(hi - lo));
            ds[ch] = -1;
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < NPIX; a++) mem[a] = 8'($urandom);
    endtask

    // Reset asserted while the read of pixel 300 is being issued.
    task automatic reset_midstream();
        bit found;
        found = 1'b0;
        for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
            @(posedge clk); #1;
            frame_start = (cyc == 0);
            hold = 1'b0;
            ch_layer_done = '0;
            @(negedge clk);
            if (img_rd_en && img_rd_addr == ADDR_W'(300)) found = 1'b1;
        end
        check_eq("rst_mid found_pixel300", found, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_mid outputs_zero",
                     {img_rd_en, img_rd_addr, ch_start, ch_valid, ch_pixel, done_mask, busy, frame_done, timeout_err}, 0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_mid quiet_after", {ch_valid, busy, img_rd_en}, 0);
            @(posedge clk); #1;
        end
        last_err = 1'b0;
        $display("reset mid-stream applied at pixel 300");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs",
                 {img_rd_en, img_rd_addr, ch_start, ch_valid, ch_pixel, done_mask, busy, frame_done, timeout_err}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycles(2);

        // Basic frame: ramp data, all channels done 10 cycles after the last pixel.
        for (int a = 0; a < NPIX; a++) mem[a] = 8'(a);
        for (int ch = 0; ch < NUM_CH; ch++) begin dw[ch] = 9; ds[ch] = -1; end
        run_frame("basic", 0, 1'b0);
        idle_cycles(2);

        // Backpressure: hold toggles every cycle.
        fill_random();
        set_done(0, 8);
        run_frame("backpressure", 1, 1'b0);
        idle_cycles(2);

        // Skewed done: ch0 early in STREAM, a ch3 flag in START that must be
        // ignored, then staggered pulses through WAIT_DONE.
        fill_random();
        for (int ch = 0; ch < NUM_CH; ch++) begin dw[ch] = 2 * ch - 1; ds[ch] = -1; end
        dw[0] = -1;
        ds[0] = 50;
        ds[3] = 1;
        run_frame("skewed", 2, 1'b0);
        idle_cycles(2);

        // Timeout: ch3 never reports done.
        fill_random();
        set_done(0, 10);
        dw[3] = -1;
        run_frame("timeout", 2, 1'b0);
        check_eq("timeout mask_37", done_mask, 6'h37);
        idle_cycles(2);

        // Busy rejection: a second frame_start mid-stream must be ignored;
        // this frame also confirms the sticky error clears on acceptance.
        fill_random();
        set_done(0, 12);
        run_frame("busy_reject", 2, 1'b1);
        idle_cycles(1);

        reset_midstream();
        fill_random();
        set_done(0, 14);
        run_frame("after_reset", 0, 1'b0);
        idle_cycles(2);

        for (int f = 0; f < 2; f++) begin
            fill_random();
            set_done(0, 14);
            if (($urandom % 2) == 0) dw[$urandom_range(NUM_CH - 1)] = -1;
            run_frame($sformatf("random%0d", f), 2, 1'b0);
            idle_cycles(1 + int'($urandom_range(3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
